// File: rtl/video_source_scheduler.sv
// video_source_scheduler: frame-aligned two-source arbiter feeding a continuous DVI pixel stream
module video_source_scheduler #(
    parameter int          Width     = 800,
    parameter int          Height    = 600,
    parameter int          XBits     = 11,
    parameter int          YBits     = 10,
    parameter logic [23:0] FillColor = 24'h000000,
    parameter int          CountBits = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 SelReq,
    input  logic [23:0]          SrcA_Video,
    input  logic                 SrcA_Valid,
    output logic                 SrcA_Ready,
    input  logic [23:0]          SrcB_Video,
    input  logic                 SrcB_Valid,
    output logic                 SrcB_Ready,
    output logic [23:0]          Video,
    output logic                 VideoValid,
    input  logic                 VideoReady,
    output logic                 Sel,
    output logic                 SwitchPending,
    output logic                 FrameStart,
    output logic [XBits-1:0]     PixelX,
    output logic [YBits-1:0]     PixelY,
    output logic                 Underflow,
    output logic [CountBits-1:0] UnderflowCount
);
    logic [XBits-1:0] lx;
    logic [YBits-1:0] ly;
    logic             load;
    logic             origin;
    logic             eff_sel;
    logic             src_valid;
    logic [23:0]      src_video;
    logic             x_last;
    logic             y_last;

    // handshake, frame-aligned source selection and counter wrap decode
    always_comb begin
        load          = ~VideoValid | VideoReady;
        origin        = (lx == '0) && (ly == '0);
        eff_sel       = origin ? SelReq : Sel;
        src_valid     = eff_sel ? SrcB_Valid : SrcA_Valid;
        src_video     = eff_sel ? SrcB_Video : SrcA_Video;
        SrcA_Ready    = load & Reset & ~eff_sel;
        SrcB_Ready    = load & Reset & eff_sel;
        SwitchPending = SelReq != Sel;
        x_last        = lx == XBits'(Width - 1);
        y_last        = ly == YBits'(Height - 1);
    end

    // output register, load counters and saturating underflow count
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Video          <= '0;
            VideoValid     <= 1'b0;
            Sel            <= 1'b0;
            PixelX         <= '0;
            PixelY         <= '0;
            FrameStart     <= 1'b0;
            Underflow      <= 1'b0;
            UnderflowCount <= '0;
            lx             <= '0;
            ly             <= '0;
        end else if (load) begin
            Video          <= src_valid ? src_video : FillColor;
            Underflow      <= ~src_valid;
            UnderflowCount <= (!src_valid && UnderflowCount != '1) ? UnderflowCount + 1'b1 : UnderflowCount;
            VideoValid     <= 1'b1;
            Sel            <= eff_sel;
            PixelX         <= lx;
            PixelY         <= ly;
            FrameStart     <= origin;
            lx             <= x_last ? '0 : lx + 1'b1;
            ly             <= x_last ? (y_last ? '0 : ly + 1'b1) : ly;
        end
    end
endmodule
